// File: rtl/screen_scanout_if.sv
// Screen scan-out bus: pixel tick in, screen-memory read port, and the display-side video signals.
// The master side is the scan-out engine; the slave side is memory plus the display sink.
interface screen_scanout_if;
    logic        pix_en;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        pixel;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        input  pix_en,
        input  scr_data,
        output scr_addr,
        output pixel,
        output de,
        output hsync,
        output vsync,
        output frame_start
    );

    modport slave (
        output pix_en,
        output scr_data,
        input  scr_addr,
        input  pixel,
        input  de,
        input  hsync,
        input  vsync,
        input  frame_start
    );
endinterface

// File: rtl/screen_scanout.sv
// Raster scan-out of the Hack screen map: walks 512x256 pixels and fetches one word per 16 columns.
// Outputs are a 1-bit pixel with hsync/vsync/de, all aligned two pixel ticks behind the counters.
module screen_scanout #(
    parameter int   H_ACTIVE = 512,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 64,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 256,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 32,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    screen_scanout_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [12:0]   scr_addr_q, scr_addr_d;
    logic [15:0]   shift_q, shift_d;
    logic          de1_q, de1_d;
    logic          hs1_q, hs1_d;
    logic          vs1_q, vs1_d;
    logic          fs1_q, fs1_d;
    logic          pixel_q, pixel_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          frame_start_q, frame_start_d;

    logic          visible_s;
    logic [12:0]   fetch_addr_s;

    assign visible_s    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign fetch_addr_s = {v_cnt_q[7:0], 5'b0_0000} + {8'b0000_0000, h_cnt_q[8:4]};

    // Next-state: counters, fetch, serialiser and the two-stage output pipeline, all gated by pix_en.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        scr_addr_d    = scr_addr_q;
        shift_d       = shift_q;
        de1_d         = de1_q;
        hs1_d         = hs1_q;
        vs1_d         = vs1_q;
        fs1_d         = fs1_q;
        pixel_d       = pixel_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = 1'b0;
        if (bus.pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + VW'(1);
                end
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end

            if (visible_s && (h_cnt_q[3:0] == 4'd0)) begin
                scr_addr_d = fetch_addr_s;
            end else begin
                scr_addr_d = scr_addr_q;
            end

            de1_d = visible_s;
            hs1_d = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vs1_d = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? SYNC_POL : ~SYNC_POL;
            fs1_d = (h_cnt_q == '0) && (v_cnt_q == '0);

            // Column 16w leaves straight from scr_data on the load tick; the rest shift out LSB-first.
            if (visible_s && (h_cnt_q[3:0] == 4'd1)) begin
                shift_d = {1'b0, bus.scr_data[15:1]};
                pixel_d = de1_q & bus.scr_data[0];
            end else begin
                shift_d = {1'b0, shift_q[15:1]};
                pixel_d = de1_q & shift_q[0];
            end

            de_d          = de1_q;
            hsync_d       = hs1_q;
            vsync_d       = vs1_q;
            frame_start_d = fs1_q & de1_q;
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset to an idle, sync-inactive display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            scr_addr_q    <= 13'd0;
            shift_q       <= 16'd0;
            de1_q         <= 1'b0;
            hs1_q         <= ~SYNC_POL;
            vs1_q         <= ~SYNC_POL;
            fs1_q         <= 1'b0;
            pixel_q       <= 1'b0;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            scr_addr_q    <= scr_addr_d;
            shift_q       <= shift_d;
            de1_q         <= de1_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            fs1_q         <= fs1_d;
            pixel_q       <= pixel_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.scr_addr    = scr_addr_q;
    assign bus.pixel       = pixel_q;
    assign bus.de          = de_q;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout with shortened porches (518 x 259 ticks per frame).
// A tick-count model predicts every output each clock; literal checks pin key points.
module tb_screen_scanout;
    localparam int HT    = 518;
    localparam int VT    = 259;
    localparam int FRAME = HT * VT;

    logic clk;
    logic reset;
    int   k;
    logic last_tick;
    int   checks;
    int   failures;
    logic toggle_mode;

    screen_scanout_if bus ();

    screen_scanout #(
        .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(int a);
        logic [31:0] x;
        if (a == 0) return 16'h0001;
        if (a == 1) return 16'h8000;
        x = (a * 32'd40503) ^ (a << 7);
        return x[15:0];
    endfunction

    // Combinational screen memory.
    always_comb bus.scr_data = mem_word(int'(bus.scr_addr));

    // Ticks seen since reset release, and whether the last edge was a tick.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k         <= 0;
            last_tick <= 1'b0;
        end else begin
            if (bus.pix_en) k <= k + 1;
            last_tick <= bus.pix_en;
        end
    end

    // Latest fetched word after n ticks: one fetch per visible 16-column group, none in blanking.
    function automatic int exp_addr(int n);
        int p, h, v;
        if (n == 0) return 0;
        p = (n - 1) % FRAME;
        h = p % HT;
        v = p / HT;
        if (v >= 256) return 8191;
        if (h >= 512) return v * 32 + 31;
        return v * 32 + h / 16;
    endfunction

    // Expected {scr_addr, pixel, de, hsync, vsync, frame_start}: outputs show position n-2.
    function automatic logic [17:0] exp_out(int n, logic lt);
        int p, h, v;
        logic [15:0] w;
        logic de_e, pix_e, hs_e, vs_e, fs_e;
        logic [12:0] a;
        a = 13'(exp_addr(n));
        if (n < 2) return {a, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        p = (n - 2) % FRAME;
        h = p % HT;
        v = p / HT;
        de_e  = (h < 512) && (v < 256);
        w     = mem_word(v * 32 + h / 16);
        pix_e = de_e ? w[h % 16] : 1'b0;
        hs_e  = !((h >= 514) && (h < 517));
        vs_e  = !(v == 257);
        fs_e  = lt && (p == 0);
        return {a, pix_e, de_e, hs_e, vs_e, fs_e};
    endfunction

    task automatic check_lit(string name, int got, int expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (tick %0d)", name, got, expv, k);
        end
    endtask

    // One clock: compare against the model on the falling edge, then drive pix_en.
    task automatic step();
        logic [17:0] got, expv;
        @(negedge clk);
        got  = {bus.scr_addr, bus.pixel, bus.de, bus.hsync, bus.vsync, bus.frame_start};
        expv = exp_out(k, last_tick);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL model tick=%0d got=%h expected=%h", k, got, expv);
        end
        if (toggle_mode) bus.pix_en = ~bus.pix_en;
        else             bus.pix_en = 1'b1;
    endtask

    task automatic run_to(int target);
        int guard;
        guard = 0;
        while (k < target && guard < 150000) begin
            step();
            guard++;
        end
        check_lit("run_to", k, target);
    endtask

    task automatic check_reset_vals(string tag);
        check_lit({tag, "_pixel"}, int'(bus.pixel), 0);
        check_lit({tag, "_de"}, int'(bus.de), 0);
        check_lit({tag, "_hsync"}, int'(bus.hsync), 1);
        check_lit({tag, "_vsync"}, int'(bus.vsync), 1);
        check_lit({tag, "_addr"}, int'(bus.scr_addr), 0);
        check_lit({tag, "_fs"}, int'(bus.frame_start), 0);
    endtask

    initial begin
        int fs_cnt;
        int guard;
        checks      = 0;
        failures    = 0;
        toggle_mode = 1'b0;
        reset       = 1'b1;
        bus.pix_en  = 1'b1;
        step();
        step();
        check_reset_vals("in_reset");
        reset = 1'b0;

        // Continuous ticks from release.
        run_to(1);
        check_lit("first_fetch", int'(bus.scr_addr), 0);
        check_lit("de_tick1", int'(bus.de), 0);
        run_to(2);
        check_lit("de_rise", int'(bus.de), 1);
        check_lit("fs_pulse", int'(bus.frame_start), 1);
        check_lit("pix_c0", int'(bus.pixel), 1);
        run_to(3);
        check_lit("fs_drop", int'(bus.frame_start), 0);
        check_lit("pix_c1", int'(bus.pixel), 0);
        run_to(17);
        check_lit("fetch_w1", int'(bus.scr_addr), 1);
        run_to(32);
        check_lit("pix_c30", int'(bus.pixel), 0);
        run_to(33);
        check_lit("pix_c31", int'(bus.pixel), 1);
        run_to(34);
        check_lit("pix_c32", int'(bus.pixel), 0);
        run_to(515);
        check_lit("hs_before", int'(bus.hsync), 1);
        run_to(516);
        check_lit("hs_start", int'(bus.hsync), 0);
        run_to(518);
        check_lit("hs_last", int'(bus.hsync), 0);
        check_lit("blank_addr", int'(bus.scr_addr), 31);
        run_to(519);
        check_lit("hs_end", int'(bus.hsync), 1);
        check_lit("line1_fetch", int'(bus.scr_addr), 32);
        run_to(520);
        check_lit("line1_de", int'(bus.de), 1);

        // Counters at line 100, column 200: reset mid-line.
        run_to(100 * HT + 200);
        check_lit("pre_reset_addr", int'(bus.scr_addr), 100 * 32 + 12);
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset");
        step();
        step();
        reset = 1'b0;
        run_to(1);
        check_lit("re_fetch", int'(bus.scr_addr), 0);
        check_lit("re_de_low", int'(bus.de), 0);
        run_to(2);
        check_lit("re_fs", int'(bus.frame_start), 1);
        check_lit("re_de", int'(bus.de), 1);
        run_to(600);

        // pix_en alternating 1,0 from a fresh frame.
        reset = 1'b1;
        step();
        step();
        reset       = 1'b0;
        bus.pix_en  = 1'b1;
        toggle_mode = 1'b1;
        fs_cnt = 0;
        guard  = 0;
        while (k < 1100 && guard < 5000) begin
            step();
            if (bus.frame_start === 1'b1) fs_cnt++;
            guard++;
        end
        check_lit("toggle_done", k, 1100);
        check_lit("toggle_fs_width", fs_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
